// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with IDLE/RUN/DONE control and optional auto-reload
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick_en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] dec_w;
    logic             borrow;

    // Borrow-out is only set when count_q is 0, which RUN never holds.
    assign sub_w  = {1'b0, count_q} - ONE_W;
    assign dec_w  = sub_w[WIDTH-1:0];
    assign borrow = sub_w[WIDTH];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    state_d  = (load_val != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick_en && !borrow) begin
                    count_d = dec_w;
                    if (dec_w == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!abort && (AUTO_RELOAD != 0) && (reload_q != '0)) begin
                    count_d = reload_q;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer, one-shot and auto-reload instances
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       s0 = 1'b0, t0 = 1'b0, a0 = 1'b0;
    logic [3:0] l0 = '0;
    logic [3:0] count0;
    logic       busy0, done0;

    logic       s1 = 1'b0, t1 = 1'b0, a1 = 1'b0;
    logic [3:0] l1 = '0;
    logic [3:0] count1;
    logic       busy1, done1;

    int checks = 0;
    int errors = 0;

    // Row layout: {start, load_val[3:0], tick_en, abort, exp_count[3:0], exp_busy, exp_done}
    logic [12:0] rows [$];
    logic [5:0]  exp_q [$];
    logic [5:0]  e;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .rst(rst), .start(s0), .load_val(l0), .tick_en(t0), .abort(a0),
        .count(count0), .busy(busy0), .done(done0)
    );

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .load_val(l1), .tick_en(t1), .abort(a1),
        .count(count1), .busy(busy1), .done(done1)
    );

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((busy0 && dut0.borrow) || (busy1 && dut1.borrow)) begin
                errors++;
                $display("FAIL borrow_in_run got b0=%b b1=%b required 0", dut0.borrow, dut1.borrow);
            end
            checks++;
            if ((busy0 && done0) || (busy1 && done1)) begin
                errors++;
                $display("FAIL busy_done_overlap got u0=%b%b u1=%b%b required no overlap",
                         busy0, done0, busy1, done1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count0, busy0, done0, count1, busy1, done1} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %h required 000",
                     {count0, busy0, done0, count1, busy1, done1});
        end
        rst = 1'b0;
    endtask

    task automatic run_rows0(input string name);
        for (int i = 0; i < rows.size(); i++) begin
            {s0, l0, t0, a0} = rows[i][12:6];
            exp_q.push_back(rows[i][5:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({count0, busy0, done0} !== e) begin
                errors++;
                $display("FAIL %s[%0d] got cnt=%0d busy=%b done=%b required cnt=%0d busy=%b done=%b",
                         name, i, count0, busy0, done0, e[5:2], e[1], e[0]);
            end
        end
        {s0, l0, t0, a0} = '0;
    endtask

    task automatic test_basic();
        rows = '{
            {1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b01},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00}
        };
        run_rows0("basic");
    endtask

    task automatic test_zero_load();
        rows = '{
            {1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 2'b01},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00},
            {1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 2'b00},
            {1'b0, 4'd7, 1'b1, 1'b0, 4'd0, 2'b00}
        };
        run_rows0("zero_load");
    endtask

    task automatic test_pause_abort();
        rows = '{
            {1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 2'b10},
            {1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b10},
            {1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b10},
            {1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b10},
            {1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 2'b00},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 2'b00},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 2'b00}
        };
        run_rows0("pause_abort");
    endtask

    task automatic test_boundary();
        rows.delete();
        rows.push_back({1'b1, 4'hF, 1'b1, 1'b0, 4'hF, 2'b10});
        for (int i = 1; i < 15; i++) begin
            rows.push_back({1'b1, 4'd2, 1'b1, 1'b0, 4'(15 - i), 2'b10});
        end
        rows.push_back({1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 2'b01});
        rows.push_back({1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 2'b00});
        rows.push_back({1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00});
        run_rows0("boundary");
    endtask

    task automatic test_auto_reload();
        rows = '{
            {1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b01},
            {1'b1, 4'd9, 1'b1, 1'b0, 4'd2, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b01},
            {1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 2'b00},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00},
            {1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 2'b01},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00}
        };
        for (int i = 0; i < rows.size(); i++) begin
            {s1, l1, t1, a1} = rows[i][12:6];
            exp_q.push_back(rows[i][5:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({count1, busy1, done1} !== e) begin
                errors++;
                $display("FAIL auto_reload[%0d] got cnt=%0d busy=%b done=%b required cnt=%0d busy=%b done=%b",
                         i, count1, busy1, done1, e[5:2], e[1], e[0]);
            end
        end
        {s1, l1, t1, a1} = '0;
    endtask

    task automatic test_async_reset();
        rows = '{
            {1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 2'b10}
        };
        run_rows0("async_pre");
        t0 = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({count0, busy0, done0} !== 6'b0000_00) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d busy=%b done=%b required cnt=0 busy=0 done=0",
                     count0, busy0, done0);
        end
        #2 rst = 1'b0;
        rows = '{
            {1'b1, 4'd4, 1'b1, 1'b0, 4'd4, 2'b10},
            {1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 2'b10},
            {1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 2'b00}
        };
        run_rows0("async_post");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_load();
        test_pause_abort();
        test_boundary();
        test_auto_reload();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
